// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC and sequences request/ack fetches
// against instruction memory, delivering each instruction downstream.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned IMEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        branch,
    input  logic        zero,
    input  logic [31:0] branchDest,
    input  logic        stall,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemRdata,
    output logic [31:0] instr,
    output logic        instrValid,
    output logic [31:0] pc,
    output logic        fetchErr
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(IMEM_TIMEOUT - 1);
    localparam logic [XLEN-1:0]  ALIGN_MASK  = ~XLEN'(3);
    localparam logic [XLEN-1:0]  RESET_PC_AL = RESET_PC & ALIGN_MASK;

    typedef enum logic [1:0] {
        S_REQ     = 2'd0,
        S_DELIVER = 2'd1,
        S_ERR     = 2'd2
    } state_e;

    state_e              state_q,       state_d;
    logic [XLEN-1:0]     fetch_pc_q,    fetch_pc_d;
    logic                imem_req_q,    imem_req_d;
    logic [XLEN-1:0]     imem_addr_q,   imem_addr_d;
    logic [XLEN-1:0]     instr_q,       instr_d;
    logic                instr_valid_q, instr_valid_d;
    logic [XLEN-1:0]     pc_q,          pc_d;
    logic                fetch_err_q,   fetch_err_d;
    logic [CNT_W-1:0]    wait_cnt_q,    wait_cnt_d;
    logic [XLEN-1:0]     target;

    // Redirect target is only meaningful on the acceptance cycle.
    always_comb begin
        if (branch && zero) begin
            target = branchDest & ALIGN_MASK;
        end else begin
            target = pc_q + XLEN'(4);
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        imem_req_d    = imem_req_q;
        imem_addr_d   = imem_addr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_d          = pc_q;
        fetch_err_d   = fetch_err_q;
        wait_cnt_d    = wait_cnt_q;

        unique case (state_q)
            S_REQ: begin
                if (!imem_req_q) begin
                    // First cycle out of reset: raise the request; stray acks are ignored.
                    imem_req_d  = 1'b1;
                    imem_addr_d = fetch_pc_q;
                    wait_cnt_d  = '0;
                end else if (imemAck) begin
                    instr_d       = imemRdata;
                    pc_d          = fetch_pc_q;
                    instr_valid_d = 1'b1;
                    imem_req_d    = 1'b0;
                    wait_cnt_d    = '0;
                    state_d       = S_DELIVER;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    fetch_err_d = 1'b1;
                    imem_req_d  = 1'b0;
                    state_d     = S_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            S_DELIVER: begin
                if (!stall) begin
                    fetch_pc_d    = target;
                    imem_addr_d   = target;
                    imem_req_d    = 1'b1;
                    instr_valid_d = 1'b0;
                    wait_cnt_d    = '0;
                    state_d       = S_REQ;
                end
            end
            S_ERR: begin
                imem_req_d    = 1'b0;
                instr_valid_d = 1'b0;
                fetch_err_d   = 1'b1;
            end
            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_REQ;
            fetch_pc_q    <= RESET_PC_AL;
            imem_req_q    <= 1'b0;
            imem_addr_q   <= RESET_PC_AL;
            instr_q       <= '0;
            instr_valid_q <= 1'b0;
            pc_q          <= RESET_PC_AL;
            fetch_err_q   <= 1'b0;
            wait_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            imem_req_q    <= imem_req_d;
            imem_addr_q   <= imem_addr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_q          <= pc_d;
            fetch_err_q   <= fetch_err_d;
            wait_cnt_q    <= wait_cnt_d;
        end
    end

    assign imemReq    = imem_req_q;
    assign imemAddr   = imem_addr_q;
    assign instr      = instr_q;
    assign instrValid = instr_valid_q;
    assign pc         = pc_q;
    assign fetchErr   = fetch_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed steps plus a randomized fetch stream
// checked against a PC-sequence reference model.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst;
    logic        branch, zero, stall;
    logic [31:0] branch_dest;

    logic        req_a, valid_a, err_a, ack_a;
    logic [31:0] addr_a, instr_a, pc_a, rd_a;
    logic        req_b, valid_b, err_b, ack_b;
    logic [31:0] addr_b, instr_b, pc_b, rd_b;

    int total = 0;
    int bad   = 0;
    logic [31:0] mpc;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .IMEM_TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .branch(branch), .zero(zero), .branchDest(branch_dest),
        .stall(stall), .imemReq(req_a), .imemAddr(addr_a), .imemAck(ack_a),
        .imemRdata(rd_a), .instr(instr_a), .instrValid(valid_a), .pc(pc_a),
        .fetchErr(err_a)
    );

    fetch_sequencer #(.RESET_PC(32'hFFFF_FFFC), .IMEM_TIMEOUT(15)) dut_b (
        .clk(clk), .rst(rst), .branch(branch), .zero(zero), .branchDest(branch_dest),
        .stall(stall), .imemReq(req_b), .imemAddr(addr_b), .imemAck(ack_b),
        .imemRdata(rd_b), .instr(instr_b), .instrValid(valid_b), .pc(pc_b),
        .fetchErr(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One full fetch on dut_a: called with the request just raised at address mpc.
    task automatic fetch_one(input int dly, input int nstall, input logic br,
                             input logic z, input logic [31:0] dest);
        logic [31:0] word;
        word = $urandom;
        for (int i = 0; i < dly; i++) begin
            ack_a  = 1'b0;
            stall  = 1'($urandom_range(0, 1));
            branch = 1'($urandom_range(0, 1));
            tick();
            chk("wait_req", 32'(req_a), 32'd1);
            chk("wait_valid", 32'(valid_a), 32'd0);
            chk("wait_addr", addr_a, mpc);
        end
        ack_a = 1'b1;
        rd_a  = word;
        tick();
        ack_a = 1'b0;
        chk("dlv_valid", 32'(valid_a), 32'd1);
        chk("dlv_instr", instr_a, word);
        chk("dlv_pc", pc_a, mpc);
        chk("dlv_req", 32'(req_a), 32'd0);
        for (int i = 0; i < nstall; i++) begin
            stall       = 1'b1;
            branch      = 1'b1;
            zero        = 1'b1;
            branch_dest = $urandom;
            ack_a       = 1'($urandom_range(0, 1));
            rd_a        = $urandom;
            tick();
            chk("stall_valid", 32'(valid_a), 32'd1);
            chk("stall_instr", instr_a, word);
            chk("stall_pc", pc_a, mpc);
            chk("stall_req", 32'(req_a), 32'd0);
        end
        ack_a       = 1'b0;
        stall       = 1'b0;
        branch      = br;
        zero        = z;
        branch_dest = dest;
        mpc = (br && z) ? {dest[31:2], 2'b00} : mpc + 32'd4;
        tick();
        chk("acc_valid", 32'(valid_a), 32'd0);
        chk("acc_req", 32'(req_a), 32'd1);
        chk("acc_addr", addr_a, mpc);
        branch = 1'b0;
        zero   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        branch = 1'b0; zero = 1'b0; stall = 1'b0; branch_dest = '0;
        ack_a = 1'b0; rd_a = '0; ack_b = 1'b0; rd_b = '0;
        #1 rst = 1'b0;
        #1;
        chk("rst_req", 32'(req_a), 32'd0);
        chk("rst_addr", addr_a, 32'h0);
        chk("rst_instr", instr_a, 32'h0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_pc", pc_a, 32'h0);
        chk("rst_err", 32'(err_a), 32'd0);
        chk("rst_b_addr", addr_b, 32'hFFFF_FFFC);
        chk("rst_b_pc", pc_b, 32'hFFFF_FFFC);

        tick();
        rst = 1'b1;
        tick();
        chk("first_req", 32'(req_a), 32'd1);
        chk("first_addr", addr_a, 32'h0);
        chk("first_valid", 32'(valid_a), 32'd0);
        mpc = 32'h0;

        // Zero-wait fetches at 0x0, 0x4; stall 3 cycles at 0x8; then 0xC.
        fetch_one(0, 0, 1'b0, 1'b0, 32'h0);
        fetch_one(0, 0, 1'b0, 1'b0, 32'h0);
        chk("pc8", mpc, 32'h8);
        fetch_one(0, 3, 1'b0, 1'b0, 32'h0);
        chk("addr_c", addr_a, 32'hC);
        fetch_one(0, 0, 1'b0, 1'b0, 32'h0);
        // Taken branch at 0x10, return, then not-taken branch at 0x10.
        fetch_one(0, 0, 1'b1, 1'b1, 32'h0000_0103);
        chk("br_taken", addr_a, 32'h100);
        fetch_one(1, 0, 1'b1, 1'b1, 32'h10);
        fetch_one(0, 0, 1'b1, 1'b0, 32'h0000_0103);
        chk("br_not_taken", addr_a, 32'h14);

        // Randomized stream; a 3-cycle delay lands the ack on the timeout cycle.
        for (int n = 0; n < 40; n++) begin
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        end

        // Timeout: four request cycles without ack.
        ack_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("to_req", 32'(req_a), 32'd1);
            chk("to_err_early", 32'(err_a), 32'd0);
        end
        tick();
        chk("to_err", 32'(err_a), 32'd1);
        chk("to_req_drop", 32'(req_a), 32'd0);
        chk("to_valid", 32'(valid_a), 32'd0);
        ack_a = 1'b1; branch = 1'b1; zero = 1'b1; branch_dest = 32'h40;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("err_sticky", 32'(err_a), 32'd1);
            chk("err_req", 32'(req_a), 32'd0);
            chk("err_valid", 32'(valid_a), 32'd0);
            chk("err_addr", addr_a, mpc);
        end
        ack_a = 1'b0; branch = 1'b0; zero = 1'b0;

        // Asynchronous reset clears the error.
        #2 rst = 1'b0;
        #1;
        chk("arst_err", 32'(err_a), 32'd0);
        chk("arst_addr", addr_a, 32'h0);
        chk("arst_b_addr", addr_b, 32'hFFFF_FFFC);
        tick();
        rst = 1'b1;
        tick();
        chk("re_req", 32'(req_a), 32'd1);
        chk("re_addr", addr_a, 32'h0);

        // Reset mid-REQ between edges, with acks present during reset.
        #2 rst = 1'b0;
        ack_a = 1'b1; ack_b = 1'b1; rd_b = 32'hCAFE_0001;
        #1;
        chk("mid_req_a", 32'(req_a), 32'd0);
        chk("mid_req_b", 32'(req_b), 32'd0);
        tick();
        chk("mid_valid_a", 32'(valid_a), 32'd0);
        chk("mid_valid_b", 32'(valid_b), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rel_valid_a", 32'(valid_a), 32'd0);
        chk("rel_req_a", 32'(req_a), 32'd1);
        chk("rel_addr_a", addr_a, 32'h0);
        chk("rel_valid_b", 32'(valid_b), 32'd0);
        chk("rel_addr_b", addr_b, 32'hFFFF_FFFC);
        ack_a = 1'b0;

        // PC wrap from 0xFFFF_FFFC on dut_b.
        tick();
        chk("wrap_dlv_valid", 32'(valid_b), 32'd1);
        chk("wrap_dlv_pc", pc_b, 32'hFFFF_FFFC);
        chk("wrap_dlv_instr", instr_b, 32'hCAFE_0001);
        ack_b = 1'b0; stall = 1'b0; branch = 1'b0;
        tick();
        chk("wrap_addr", addr_b, 32'h0);
        chk("wrap_req", 32'(req_b), 32'd1);
        ack_b = 1'b1; rd_b = 32'hCAFE_0002;
        tick();
        chk("wrap_pc0", pc_b, 32'h0);
        chk("wrap_instr0", instr_b, 32'hCAFE_0002);
        ack_b = 1'b0;
        tick();
        chk("wrap_addr4", addr_b, 32'h4);

        // Default-sized timeout on dut_b: fifteen request cycles.
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("b_to_early", 32'(err_b), 32'd0);
            chk("b_to_req", 32'(req_b), 32'd1);
        end
        tick();
        chk("b_to_err", 32'(err_b), 32'd1);
        chk("b_to_req_drop", 32'(req_b), 32'd0);
        chk("a_err_idle", 32'(err_a), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
